// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the load buffer and the committed-store buffer.
// One dmem request is outstanding at most. A new request can issue in the same cycle as dmem_resp.
module dmem_port_arbiter #(
  parameter int ROB_IDX_W    = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 ld_req_valid,
  output logic                 ld_req_ready,
  input  logic [31:0]          ld_req_addr,
  input  logic [3:0]           ld_req_rmask,
  input  logic [ROB_IDX_W-1:0] ld_req_tag,
  input  logic                 st_req_valid,
  input  logic                 st_req_urgent,
  output logic                 st_req_ready,
  input  logic [31:0]          st_req_addr,
  input  logic [3:0]           st_req_wmask,
  input  logic [31:0]          st_req_wdata,
  input  logic [ROB_IDX_W-1:0] st_req_tag,
  output logic                 ld_resp_valid,
  output logic [ROB_IDX_W-1:0] ld_resp_tag,
  output logic [31:0]          ld_resp_rdata,
  output logic                 st_done_valid,
  output logic [ROB_IDX_W-1:0] st_done_tag,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_rmask,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_resp
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LD = 2'd1,
    WAIT_ST = 2'd2
  } state_t;

  state_t               state_r, state_next_s;
  logic [CNT_W-1:0]     starve_cnt_r, starve_next_s;
  logic                 kill_r, kill_next_s;
  logic [ROB_IDX_W-1:0] tag_r;
  logic                 slot_s, ld_eligible_s, st_win_s, ld_win_s;
  logic                 unused_addr_lsb_s;

  // The byte offset is dropped because dmem is word-addressed.
  assign unused_addr_lsb_s = ^{ld_req_addr[1:0], st_req_addr[1:0]};

  // Issue-slot arbitration. Stores win when urgent, when starved, or when no load can go.
  always_comb begin
    slot_s        = (state_r == IDLE) || dmem_resp;
    ld_eligible_s = ld_req_valid && !flush;
    st_win_s      = slot_s && st_req_valid &&
                    (st_req_urgent || (starve_cnt_r >= CNT_W'(STARVE_LIMIT)) || !ld_eligible_s);
    ld_win_s      = slot_s && !st_win_s && ld_eligible_s;
    ld_req_ready  = ld_win_s;
    st_req_ready  = st_win_s;
  end

  // Next-state logic for the FSM, the starvation counter and the kill flag.
  always_comb begin
    state_next_s  = state_r;
    starve_next_s = starve_cnt_r;
    kill_next_s   = kill_r;
    case (state_r)
      IDLE, WAIT_LD, WAIT_ST: begin
        if (st_win_s) begin
          state_next_s = WAIT_ST;
        end else if (ld_win_s) begin
          state_next_s = WAIT_LD;
        end else if (slot_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = IDLE;
    endcase

    if (st_win_s) begin
      starve_next_s = '0;
    end else if (ld_win_s && st_req_valid && (starve_cnt_r < CNT_W'(STARVE_LIMIT))) begin
      starve_next_s = starve_cnt_r + CNT_W'(1);
    end else begin
      starve_next_s = starve_cnt_r;
    end

    // A flush that coincides with dmem_resp is handled directly at the response register.
    if (st_win_s || ld_win_s) begin
      kill_next_s = 1'b0;
    end else if ((state_r == WAIT_LD) && flush && !dmem_resp) begin
      kill_next_s = 1'b1;
    end else begin
      kill_next_s = kill_r;
    end
  end

  // State, the dmem request registers and the response pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      starve_cnt_r  <= '0;
      kill_r        <= 1'b0;
      tag_r         <= '0;
      dmem_addr     <= 32'd0;
      dmem_rmask    <= 4'd0;
      dmem_wmask    <= 4'd0;
      dmem_wdata    <= 32'd0;
      ld_resp_valid <= 1'b0;
      ld_resp_tag   <= '0;
      ld_resp_rdata <= 32'd0;
      st_done_valid <= 1'b0;
      st_done_tag   <= '0;
    end else begin
      state_r      <= state_next_s;
      starve_cnt_r <= starve_next_s;
      kill_r       <= kill_next_s;

      if (st_win_s) begin
        dmem_addr  <= {st_req_addr[31:2], 2'b00};
        dmem_wdata <= st_req_wdata;
        dmem_wmask <= st_req_wmask;
        dmem_rmask <= 4'd0;
        tag_r      <= st_req_tag;
      end else if (ld_win_s) begin
        dmem_addr  <= {ld_req_addr[31:2], 2'b00};
        dmem_rmask <= ld_req_rmask;
        dmem_wmask <= 4'd0;
        tag_r      <= ld_req_tag;
      end else begin
        dmem_rmask <= 4'd0;
        dmem_wmask <= 4'd0;
      end

      ld_resp_valid <= (state_r == WAIT_LD) && dmem_resp && !kill_r && !flush;
      if ((state_r == WAIT_LD) && dmem_resp) begin
        ld_resp_rdata <= dmem_rdata;
        ld_resp_tag   <= tag_r;
      end

      st_done_valid <= (state_r == WAIT_ST) && dmem_resp;
      if ((state_r == WAIT_ST) && dmem_resp) begin
        st_done_tag <= tag_r;
      end
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomized scoreboard bench for dmem_port_arbiter. The bench acts as the requesters and as a word memory.
module tb_dmem_port_arbiter;
  localparam int ROB_IDX_W    = 5;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic rst, flush;
  logic ld_req_valid, ld_req_ready, st_req_valid, st_req_urgent, st_req_ready;
  logic [31:0] ld_req_addr, st_req_addr, st_req_wdata;
  logic [3:0]  ld_req_rmask, st_req_wmask;
  logic [ROB_IDX_W-1:0] ld_req_tag, st_req_tag, ld_resp_tag, st_done_tag;
  logic ld_resp_valid, st_done_valid, dmem_resp;
  logic [31:0] ld_resp_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_rmask, dmem_wmask;

  dmem_port_arbiter #(.ROB_IDX_W(ROB_IDX_W), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_addr(ld_req_addr),
    .ld_req_rmask(ld_req_rmask), .ld_req_tag(ld_req_tag),
    .st_req_valid(st_req_valid), .st_req_urgent(st_req_urgent), .st_req_ready(st_req_ready),
    .st_req_addr(st_req_addr), .st_req_wmask(st_req_wmask), .st_req_wdata(st_req_wdata),
    .st_req_tag(st_req_tag),
    .ld_resp_valid(ld_resp_valid), .ld_resp_tag(ld_resp_tag), .ld_resp_rdata(ld_resp_rdata),
    .st_done_valid(st_done_valid), .st_done_tag(st_done_tag),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_st;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } iss_t;
  typedef struct {
    logic [ROB_IDX_W-1:0] tag;
    logic [31:0]          data;
  } ldr_t;

  iss_t iss_q[$];
  ldr_t ld_q[$];
  logic [ROB_IDX_W-1:0] st_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Requester and memory model state
  logic [31:0] mem [16];
  bit ld_pend, st_pend;
  logic [31:0] ld_a, st_a, st_d;
  logic [3:0]  ld_m, st_m;
  logic [ROB_IDX_W-1:0] ld_t, st_t;
  int outst = 0;          // 0 none, 1 load, 2 store
  int wait_c = 0;
  logic [ROB_IDX_W-1:0] out_tag;
  logic [31:0] out_data;
  bit out_killed;
  int starve = 0;
  int ld_acc = 0, st_acc = 0;
  int p_ld = 0, p_st = 0, p_urg = 0, p_flush = 0, lat_force = 0;
  bit in_rst = 1'b0, flush_force = 1'b0, force_resp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic new_load();
    ld_pend = 1'b1;
    ld_a = 32'h0000_1000 + 32'($urandom_range(63));
    ld_m = 4'($urandom_range(15, 1));
    ld_t = ROB_IDX_W'($urandom);
  endtask

  task automatic new_store();
    st_pend = 1'b1;
    st_a = 32'h0000_1000 + 32'($urandom_range(63));
    st_m = 4'($urandom_range(15, 1));
    st_d = $urandom;
    st_t = ROB_IDX_W'($urandom);
  endtask

  // One clock cycle: drive inputs, predict the arbitration result, update the model.
  task automatic step();
    bit resp_now, slot, elig, ldw, stw, fl;
    int lat;
    logic [31:0] w;
    if (!ld_pend && ($urandom_range(99) < p_ld)) new_load();
    if (!st_pend && ($urandom_range(99) < p_st)) new_store();
    resp_now = 1'b0;
    if (!in_rst && outst != 0) begin
      wait_c--;
      resp_now = (wait_c == 0);
    end
    fl = flush_force || ($urandom_range(99) < p_flush);
    rst           = in_rst;
    flush         = fl;
    ld_req_valid  = ld_pend && !in_rst;
    ld_req_addr   = ld_a;
    ld_req_rmask  = ld_m;
    ld_req_tag    = ld_t;
    st_req_valid  = st_pend && !in_rst;
    st_req_urgent = st_pend && ($urandom_range(99) < p_urg);
    st_req_addr   = st_a;
    st_req_wmask  = st_m;
    st_req_wdata  = st_d;
    st_req_tag    = st_t;
    dmem_resp     = resp_now || force_resp;
    dmem_rdata    = (resp_now && outst == 1) ? out_data : $urandom;
    #1;
    if (!in_rst) begin
      if (outst == 1 && fl) out_killed = 1'b1;
      slot = (outst == 0) || resp_now;
      if (resp_now) begin
        if (outst == 1 && !out_killed) ld_q.push_back('{tag: out_tag, data: out_data});
        if (outst == 2) st_q.push_back(out_tag);
        outst = 0;
      end
      elig = ld_pend && !fl;
      stw  = slot && st_pend && (st_req_urgent || (starve >= STARVE_LIMIT) || !elig);
      ldw  = slot && !stw && elig;
      chk("ld_req_ready", ld_req_ready, ldw);
      chk("st_req_ready", st_req_ready, stw);
      lat = (lat_force != 0) ? lat_force : $urandom_range(3, 1);
      if (ldw) begin
        iss_q.push_back('{is_st: 1'b0, addr: {ld_a[31:2], 2'b00}, mask: ld_m, wdata: 32'd0});
        outst = 1; wait_c = lat; out_tag = ld_t; out_killed = 1'b0;
        out_data = mem[ld_a[5:2]];
        if (st_pend) starve = (starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : starve + 1;
        ld_pend = 1'b0; ld_acc++;
      end
      if (stw) begin
        iss_q.push_back('{is_st: 1'b1, addr: {st_a[31:2], 2'b00}, mask: st_m, wdata: st_d});
        w = mem[st_a[5:2]];
        for (int b = 0; b < 4; b++) if (st_m[b]) w[8*b +: 8] = st_d[8*b +: 8];
        mem[st_a[5:2]] = w;
        outst = 2; wait_c = lat; out_tag = st_t; starve = 0;
        st_pend = 1'b0; st_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every dmem issue and every response pulse must match the next expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (dmem_rmask != 4'd0 || dmem_wmask != 4'd0) begin
        if (iss_q.size() == 0) begin
          chk("issue_spurious", {dmem_rmask, dmem_wmask}, 8'd0);
        end else begin
          iss_t e;
          e = iss_q.pop_front();
          chk("issue_addr", dmem_addr, e.addr);
          if (e.is_st) begin
            chk("issue_wmask", dmem_wmask, e.mask);
            chk("issue_wdata", dmem_wdata, e.wdata);
            chk("issue_st_rmask", dmem_rmask, 4'd0);
          end else begin
            chk("issue_rmask", dmem_rmask, e.mask);
            chk("issue_ld_wmask", dmem_wmask, 4'd0);
          end
        end
      end
      if (ld_resp_valid) begin
        if (ld_q.size() == 0) begin
          chk("ld_resp_spurious", ld_resp_valid, 1'b0);
        end else begin
          ldr_t r;
          r = ld_q.pop_front();
          chk("ld_resp_tag", ld_resp_tag, r.tag);
          chk("ld_resp_rdata", ld_resp_rdata, r.data);
        end
      end
      if (st_done_valid) begin
        if (st_q.size() == 0) chk("st_done_spurious", st_done_valid, 1'b0);
        else chk("st_done_tag", st_done_tag, st_q.pop_front());
      end
    end
  end

  initial begin
    int l0, s0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    ld_pend = 1'b0; st_pend = 1'b0;
    ld_a = 32'd0; ld_m = 4'd0; ld_t = '0; st_a = 32'd0; st_m = 4'd0; st_d = 32'd0; st_t = '0;
    out_tag = '0; out_data = 32'd0; out_killed = 1'b0;
    rst = 1'b1; flush = 1'b0; dmem_resp = 1'b0; dmem_rdata = 32'd0;
    ld_req_valid = 1'b0; st_req_valid = 1'b0; st_req_urgent = 1'b0;
    ld_req_addr = 32'd0; ld_req_rmask = 4'd0; ld_req_tag = '0;
    st_req_addr = 32'd0; st_req_wmask = 4'd0; st_req_wdata = 32'd0; st_req_tag = '0;
    @(posedge clk); #1;
    in_rst = 1'b1;
    repeat (3) step();
    chk("rst_ld_resp_valid", ld_resp_valid, 1'b0);
    chk("rst_st_done_valid", st_done_valid, 1'b0);
    chk("rst_dmem_rmask", dmem_rmask, 4'd0);
    chk("rst_dmem_wmask", dmem_wmask, 4'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    in_rst = 1'b0;

    // Lone load at 0x1003, response three cycles after issue
    mem[0] = 32'hAABB_CCDD;
    ld_pend = 1'b1; ld_a = 32'h0000_1003; ld_m = 4'b0100; ld_t = ROB_IDX_W'(7);
    lat_force = 3;
    repeat (8) step();

    // Continuous loads against a waiting store: the store goes after STARVE_LIMIT loads
    lat_force = 1; p_ld = 100;
    new_store();
    l0 = ld_acc; s0 = st_acc;
    for (int i = 0; i < 50 && st_acc == s0; i++) step();
    chk("starve_loads_before_store", ld_acc - l0, STARVE_LIMIT);
    chk("starve_store_issued", st_acc - s0, 1);
    p_ld = 0;
    repeat (6) step();

    // Urgent store overtakes a pending load
    new_load(); new_store(); p_urg = 100;
    s0 = st_acc; l0 = ld_acc;
    step();
    chk("urgent_store_first", st_acc - s0, 1);
    chk("urgent_load_waits", ld_acc - l0, 0);
    p_urg = 0;
    repeat (8) step();

    // Flush one cycle before the response; a second load issues in the response cycle
    lat_force = 3;
    new_load();
    step();
    step();
    flush_force = 1'b1; new_load();
    step();
    flush_force = 1'b0;
    l0 = ld_acc;
    step();
    chk("issue_in_killed_resp_cycle", ld_acc - l0, 1);
    repeat (6) step();

    // Randomized traffic
    lat_force = 0; p_ld = 60; p_st = 40; p_urg = 10; p_flush = 8;
    repeat (3000) step();
    p_ld = 0; p_st = 0; p_flush = 0; p_urg = 0;
    repeat (30) step();

    // Reset while a store is outstanding, followed by a late dmem_resp
    lat_force = 6;
    new_store();
    s0 = st_acc;
    for (int i = 0; i < 10 && st_acc == s0; i++) step();
    chk("rst_test_store_issued", st_acc - s0, 1);
    in_rst = 1'b1;
    step();
    in_rst = 1'b0;
    outst = 0; starve = 0;
    iss_q.delete(); ld_q.delete(); st_q.delete();
    force_resp = 1'b1;
    step();
    force_resp = 1'b0;
    chk("rst_mid_no_st_done", st_done_valid, 1'b0);
    chk("rst_mid_rmask", dmem_rmask, 4'd0);
    chk("rst_mid_wmask", dmem_wmask, 4'd0);
    lat_force = 1;
    new_load();
    repeat (5) step();

    chk("iss_q_drained", iss_q.size(), 0);
    chk("ld_q_drained", ld_q.size(), 0);
    chk("st_q_drained", st_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
